// File: rtl/mcs4_addr_stack.sv
// MCS-4 program counter with circular return-address stack.
// One sequencing command is applied per instruction cycle on the X3 edge.
// The PC is presented nibble-serially during A1..A3.
module mcs4_addr_stack #(
  parameter int ADDR_W   = 12,
  parameter int CHAR_W   = 4,
  parameter int DEPTH    = 4,
  parameter int OVF_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               icyc,
  input  logic [2:0]               cmd,
  input  logic [ADDR_W-1:0]        tgt,
  output logic [ADDR_W-1:0]        pc,
  output logic [CHAR_W-1:0]        addr_nib,
  output logic                     addr_drive,
  output logic [$clog2(DEPTH)-1:0] depth,
  output logic                     ovf,
  output logic                     unf,
  input  logic                     flag_clr
);

  localparam int NIBS = ADDR_W / CHAR_W;
  localparam int LVL  = DEPTH - 1;
  localparam int DW   = $clog2(DEPTH);
  localparam int PW   = (LVL > 1) ? $clog2(LVL) : 1;

  typedef enum logic [2:0] {
    C_NEXT  = 3'd0,
    C_JUMP  = 3'd1,
    C_CALL  = 3'd2,
    C_RET   = 3'd3,
    C_SHORT = 3'd4,
    C_HOLD  = 3'd5
  } cmd_e;

  // The address must split into one to three whole bus characters.
  if ((ADDR_W % CHAR_W) != 0 || NIBS < 1 || NIBS > 3 || DEPTH < 2) begin : g_bad_cfg
    $error("mcs4_addr_stack: unsupported ADDR_W/CHAR_W/DEPTH combination");
  end

  logic [ADDR_W-1:0] stk [LVL];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     wp_inc, wp_dec;
  logic [ADDR_W-1:0] inc, short_pc;
  logic              x3, full, empty;

  assign x3     = (icyc == 3'd7);
  assign inc    = pc + 1'b1;
  assign full   = (depth == DW'(LVL));
  assign empty  = (depth == '0);
  assign wp_inc = (wp == PW'(LVL - 1)) ? '0 : wp + 1'b1;
  assign wp_dec = (wp == '0) ? PW'(LVL - 1) : wp - 1'b1;

  // SHORT keeps the page of the incremented PC and replaces the low byte.
  always_comb begin
    short_pc = inc;
    for (int i = 0; i < ADDR_W && i < 8; i++) short_pc[i] = tgt[i];
  end

  // PC, stack and sticky flags; flag sets are written last so they beat flag_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      depth <= '0;
      wp    <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      for (int i = 0; i < LVL; i++) stk[i] <= '0;
    end else begin
      if (flag_clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (x3) begin
        case (cmd_e'(cmd))
          C_JUMP:  pc <= tgt;
          C_CALL: begin
            pc <= tgt;
            if (full) ovf <= 1'b1;
            // Wrap mode overwrites the oldest entry; hold mode drops the push.
            if (!full || OVF_MODE == 0) begin
              stk[wp] <= inc;
              wp      <= wp_inc;
              if (!full) depth <= depth + 1'b1;
            end
          end
          C_RET: begin
            if (empty) unf <= 1'b1;
            // Wrap mode returns a stale entry on underflow; hold mode falls through.
            if (!empty || OVF_MODE == 0) begin
              pc <= stk[wp_dec];
              wp <= wp_dec;
              if (!empty) depth <= depth - 1'b1;
            end else begin
              pc <= inc;
            end
          end
          C_SHORT: pc <= short_pc;
          C_HOLD:  ;
          default: pc <= inc;
        endcase
      end
    end
  end

  // Nibble-serial address bus, low character first at A1.
  always_comb begin
    addr_nib   = '0;
    addr_drive = 1'b0;
    for (int k = 0; k < NIBS; k++) begin
      if (icyc == 3'(k)) begin
        addr_nib   = pc[k*CHAR_W +: CHAR_W];
        addr_drive = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mcs4_addr_stack.sv
// Directed bench: three instances (4004 wrap, 4004 hold, 8-deep wrap) share one stimulus stream.
module tb_mcs4_addr_stack;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, CALL = 3'd2, RET = 3'd3,
                         SHORT = 3'd4, HOLD = 3'd5;

  logic        clk, rst, flag_clr;
  logic [2:0]  icyc, cmd;
  logic [11:0] tgt;

  logic [11:0] pc0, pc1, pc2;
  logic [3:0]  nib0, nib1, nib2;
  logic        drv0, drv1, drv2;
  logic [1:0]  dep0, dep1;
  logic [2:0]  dep2;
  logic        ovf0, ovf1, ovf2, unf0, unf1, unf2;

  int n_chk = 0;
  int n_fail = 0;

  mcs4_addr_stack u0 (
    .clk(clk), .rst(rst), .icyc(icyc), .cmd(cmd), .tgt(tgt), .pc(pc0),
    .addr_nib(nib0), .addr_drive(drv0), .depth(dep0), .ovf(ovf0), .unf(unf0),
    .flag_clr(flag_clr));

  mcs4_addr_stack #(.OVF_MODE(1)) u1 (
    .clk(clk), .rst(rst), .icyc(icyc), .cmd(cmd), .tgt(tgt), .pc(pc1),
    .addr_nib(nib1), .addr_drive(drv1), .depth(dep1), .ovf(ovf1), .unf(unf1),
    .flag_clr(flag_clr));

  mcs4_addr_stack #(.DEPTH(8)) u2 (
    .clk(clk), .rst(rst), .icyc(icyc), .cmd(cmd), .tgt(tgt), .pc(pc2),
    .addr_nib(nib2), .addr_drive(drv2), .depth(dep2), .ovf(ovf2), .unf(unf2),
    .flag_clr(flag_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step icyc from..to, one clock per phase, inputs changed 1 time unit after the edge.
  task automatic steps(input logic [2:0] c, input logic [11:0] t, input int from, input int to);
    for (int k = from; k <= to; k++) begin
      icyc = 3'(k);
      cmd  = c;
      tgt  = t;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic instr(input logic [2:0] c, input logic [11:0] t);
    steps(c, t, 0, 7);
    icyc = 3'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    icyc = 3'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flag_clr = 1'b0; icyc = 3'd0; cmd = NEXT; tgt = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pc", pc0, 0);
    chk("rst_depth", dep0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_unf", unf0, 0);
    chk("rst_drive_a1", drv0, 1);
    rst = 1'b0;

    // Three NEXTs, then watch the bus through a HOLD cycle.
    instr(NEXT, 0); instr(NEXT, 0); instr(NEXT, 0);
    chk("next3_pc", pc0, 12'h003);
    for (int k = 0; k < 8; k++) begin
      icyc = 3'(k);
      cmd  = HOLD;
      #1;
      chk($sformatf("nib_k%0d", k), nib0, (k == 0) ? 3 : 0);
      chk($sformatf("drv_k%0d", k), drv0, (k < 3) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    icyc = 3'd0;
    chk("hold_pc", pc0, 12'h003);

    // SHORT page handling and PC wrap.
    instr(JUMP, 12'h0FF); chk("jump_pc", pc0, 12'h0FF);
    instr(SHORT, 12'h042); chk("short_pageend", pc0, 12'h142);
    instr(JUMP, 12'h0FE); instr(SHORT, 12'h042); chk("short_inpage", pc0, 12'h042);
    instr(JUMP, 12'hFFF); instr(NEXT, 0); chk("next_wrap", pc0, 12'h000);
    instr(3'd6, 0); chk("cmd6_next", pc0, 12'h001);
    instr(3'd7, 0); chk("cmd7_next", pc0, 12'h002);

    // Nested calls, overflow, and returns in both overflow modes.
    do_reset();
    instr(JUMP, 12'h010);
    instr(CALL, 12'h100); instr(CALL, 12'h200); instr(CALL, 12'h300);
    chk("call3_depth", dep0, 3);
    chk("call3_ovf", ovf0, 0);
    chk("call3_pc", pc0, 12'h300);
    instr(CALL, 12'h400);
    chk("call4_ovf_w", ovf0, 1);
    chk("call4_depth_w", dep0, 3);
    chk("call4_pc_w", pc0, 12'h400);
    chk("call4_ovf_h", ovf1, 1);
    chk("call4_depth_h", dep1, 3);
    chk("call4_pc_h", pc1, 12'h400);
    chk("call4_depth_d8", dep2, 4);
    chk("call4_ovf_d8", ovf2, 0);
    instr(RET, 0);
    chk("ret1_w", pc0, 12'h301); chk("ret1_h", pc1, 12'h201); chk("ret1_d8", pc2, 12'h301);
    instr(RET, 0);
    chk("ret2_w", pc0, 12'h201); chk("ret2_h", pc1, 12'h101);
    instr(RET, 0);
    chk("ret3_w", pc0, 12'h101); chk("ret3_h", pc1, 12'h011);
    chk("ret3_depth_w", dep0, 0);
    instr(RET, 0);
    chk("unf_pc_h", pc1, 12'h012);
    chk("unf_flag_h", unf1, 1);
    chk("unf_depth_h", dep1, 0);
    chk("unf_pc_w", pc0, 12'h301);
    chk("unf_flag_w", unf0, 1);
    chk("unf_depth_w", dep0, 0);
    chk("ovf_sticky_w", ovf0, 1);
    chk("ret4_d8", pc2, 12'h011);
    chk("unf_d8", unf2, 0);

    // flag_clr alone clears both flags outside X3.
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    chk("clr_ovf", ovf0, 0);
    chk("clr_unf", unf0, 0);
    chk("clr_pc_kept", pc0, 12'h301);

    // Eight-deep stack: strict LIFO through seven levels.
    do_reset();
    for (int i = 1; i <= 7; i++) instr(CALL, 12'(i * 12'h100));
    chk("d8_depth7", dep2, 7);
    chk("d8_pc", pc2, 12'h700);
    for (int i = 6; i >= 0; i--) begin
      instr(RET, 0);
      chk($sformatf("d8_ret_%0d", i), pc2, i * 12'h100 + 1);
    end
    chk("d8_ovf0", ovf2, 0);
    chk("d8_depth0", dep2, 0);
    for (int i = 1; i <= 7; i++) instr(CALL, 12'(i * 12'h100));
    flag_clr = 1'b1;
    instr(CALL, 12'h800);
    flag_clr = 1'b0;
    chk("d8_ovf_beats_clr", ovf2, 1);
    chk("d8_depth_full", dep2, 7);

    // A command presented outside X3 has no effect.
    do_reset();
    instr(JUMP, 12'h123);
    steps(JUMP, 12'h555, 0, 6);
    chk("nonx3_pc", pc0, 12'h123);
    steps(HOLD, 12'h555, 7, 7);
    icyc = 3'd0;
    chk("nonx3_hold", pc0, 12'h123);

    // Reset mid-instruction wins over a pending CALL.
    do_reset();
    instr(RET, 0);
    instr(JUMP, 12'h040);
    instr(CALL, 12'h080);
    chk("pre_rst_depth", dep0, 1);
    chk("pre_rst_unf", unf0, 1);
    steps(CALL, 12'h0C0, 0, 4);
    rst = 1'b1;
    steps(CALL, 12'h0C0, 5, 5);
    rst = 1'b0;
    icyc = 3'd0;
    chk("midrst_pc", pc0, 0);
    chk("midrst_depth", dep0, 0);
    chk("midrst_unf", unf0, 0);
    chk("midrst_ovf", ovf0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
